// File: rtl/spiker_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spiker_pkg
//  Purpose  : Shared definitions for the spike feeder: frame sequencer state
//             encoding and the default sizing constants.
//  Revision : 1.0 - initial release
// ============================================================================
package spiker_pkg;

    localparam int c_n_in  = 4;   // input spike vector width
    localparam int c_n_out = 2;   // output spike vector width
    localparam int c_depth = 8;   // sample FIFO entries (power of 2, >= 2)
    localparam int c_cnt_w = 8;   // per-output spike counter width

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_RUN    = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/spike_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : spike_fifo
//  Purpose  : Synchronous FIFO with first-word fall-through read data. Also
//             tracks how many stored entries have their MSB (marker bit) set.
//  Ports    : clk, rst_n        - clock, asynchronous active-low reset
//             wr_en, wr_data    - push (ignored while full)
//             rd_en, rd_data    - pop (ignored while empty); rd_data = head
//             full, empty, count- occupancy status
//             mark_avail        - at least one stored entry has MSB = 1
//  Revision : 1.0 - initial release
// ============================================================================
module spike_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     mark_avail
);

    localparam int c_AW = $clog2(DEPTH);
    localparam logic [c_AW:0] c_FULL = (c_AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic [c_AW:0]    r_mark_cnt;

    logic w_push;
    logic w_pop;
    logic w_push_mark;
    logic w_pop_mark;

    assign full       = (r_count == c_FULL);
    assign empty      = (r_count == '0);
    assign count      = r_count;
    assign mark_avail = (r_mark_cnt != '0);
    assign rd_data    = r_mem[r_rd_ptr];

    assign w_push      = wr_en & ~full;
    assign w_pop       = rd_en & ~empty;
    assign w_push_mark = w_push & wr_data[WIDTH-1];
    assign w_pop_mark  = w_pop  & rd_data[WIDTH-1];

    // Storage is not reset; validity is carried entirely by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_mark_cnt <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count    <= r_count + {{c_AW{1'b0}}, w_push} - {{c_AW{1'b0}}, w_pop};
            r_mark_cnt <= r_mark_cnt + {{c_AW{1'b0}}, w_push_mark}
                                     - {{c_AW{1'b0}}, w_pop_mark};
        end
    end

endmodule
`default_nettype wire

// File: rtl/spike_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : spike_feeder
//  Purpose  : Buffers host spike samples and feeds them, one per network
//             sample request, into a spiking network; accumulates the
//             network's output spikes per frame.
//  Ports    : clk, rst_n                     - clock, async active-low reset
//             wr_valid/wr_ready/wr_data/wr_last - host sample write port
//             start, sample_ready, ready, sample, in_spikes, out_spikes
//                                            - network handshake and data
//             res_valid, res_counts          - frame done pulse and totals
//             err_underflow                  - sticky sample-underflow flag
//             busy                           - frame in progress
//  Revision : 1.0 - initial release
// ============================================================================
module spike_feeder
    import spiker_pkg::*;
#(
    parameter int N_IN  = c_n_in,
    parameter int N_OUT = c_n_out,
    parameter int DEPTH = c_depth,
    parameter int CNT_W = c_cnt_w
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [N_IN-1:0]          wr_data,
    input  logic                     wr_last,
    output logic                     start,
    output logic                     sample_ready,
    input  logic                     ready,
    input  logic                     sample,
    output logic [N_IN-1:0]          in_spikes,
    input  logic [N_OUT-1:0]         out_spikes,
    output logic                     res_valid,
    output logic [N_OUT*CNT_W-1:0]   res_counts,
    output logic                     err_underflow,
    output logic                     busy
);

    state_t r_state;
    state_t w_next;

    logic                     r_sample_d;
    logic                     r_rst_done;
    logic                     w_sample_rise;
    logic                     w_launch;
    logic                     w_pop;
    logic                     w_underflow;
    logic                     w_fifo_full;
    logic                     w_fifo_empty;
    logic                     w_mark_avail;
    logic [N_IN:0]            w_rd_data;
    logic [$clog2(DEPTH):0]   w_fifo_count;

    // wr_ready stays low through reset and rises on the first clock after it.
    assign wr_ready      = r_rst_done & ~w_fifo_full;
    assign w_sample_rise = sample & ~r_sample_d;
    assign w_pop         = (r_state == ST_RUN) & w_sample_rise & ~w_fifo_empty;
    // A request while the network is consuming the frame but nothing is queued.
    assign w_underflow   = ((r_state == ST_RUN) | (r_state == ST_DRAIN))
                           & w_sample_rise & w_fifo_empty;

    spike_fifo #(
        .WIDTH (N_IN + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_valid & wr_ready),
        .wr_data    ({wr_last, wr_data}),
        .rd_en      (w_pop),
        .rd_data    (w_rd_data),
        .full       (w_fifo_full),
        .empty      (w_fifo_empty),
        .count      (w_fifo_count),
        .mark_avail (w_mark_avail)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_sample_d    <= 1'b0;
            r_rst_done    <= 1'b0;
            in_spikes     <= '0;
            err_underflow <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_sample_d <= sample;
            r_rst_done <= 1'b1;
            if (w_pop) begin
                in_spikes <= w_rd_data[N_IN-1:0];
            end else if (w_underflow || r_state == ST_DONE) begin
                in_spikes <= '0;
            end
            if (w_underflow) begin
                err_underflow <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next       = r_state;
        w_launch     = 1'b0;
        start        = 1'b0;
        busy         = 1'b0;
        res_valid    = 1'b0;
        sample_ready = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Launch only once a complete frame (its last sample) is queued.
                if (w_mark_avail && ready) begin
                    w_next   = ST_LAUNCH;
                    w_launch = 1'b1;
                end
            end
            ST_LAUNCH: begin
                start        = 1'b1;
                busy         = 1'b1;
                sample_ready = (w_fifo_count != '0);
                if (!ready) w_next = ST_RUN;
            end
            ST_RUN: begin
                busy         = 1'b1;
                sample_ready = (w_fifo_count != '0);
                if (w_pop && w_rd_data[N_IN]) w_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                // The last sample is already on in_spikes when DRAIN is entered.
                busy = 1'b1;
                if (ready) w_next = ST_DONE;
            end
            ST_DONE: begin
                res_valid = 1'b1;
                w_next    = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Saturating per-output counters; their value is also the result, so the
    // totals persist until the next launch clears them.
    for (genvar i = 0; i < N_OUT; i++) begin : g_cnt
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W:0]   w_sum;

        assign w_sum = {1'b0, r_cnt} + {{CNT_W{1'b0}}, out_spikes[i]};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= '0;
            end else if (w_launch) begin
                r_cnt <= '0;
            end else if (busy) begin
                r_cnt <= w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
            end
        end

        assign res_counts[i*CNT_W +: CNT_W] = r_cnt;
    end

endmodule
`default_nettype wire

// File: tb/tb_spike_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spike_feeder
//  Purpose  : Self-checking bench for spike_feeder (N_IN=4, N_OUT=2, DEPTH=8,
//             CNT_W=4). A frame-level model predicts every output each cycle;
//             directed scenarios add literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spike_feeder;

    localparam int N_IN  = 4;
    localparam int N_OUT = 2;
    localparam int DEPTH = 8;
    localparam int CNT_W = 4;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic                   clk;
    logic                   rst_n;
    logic                   wr_valid;
    logic                   wr_ready;
    logic [N_IN-1:0]        wr_data;
    logic                   wr_last;
    logic                   start;
    logic                   sample_ready;
    logic                   ready;
    logic                   sample;
    logic [N_IN-1:0]        in_spikes;
    logic [N_OUT-1:0]       out_spikes;
    logic                   res_valid;
    logic [N_OUT*CNT_W-1:0] res_counts;
    logic                   err_underflow;
    logic                   busy;

    spike_feeder #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_data       (wr_data),
        .wr_last       (wr_last),
        .start         (start),
        .sample_ready  (sample_ready),
        .ready         (ready),
        .sample        (sample),
        .in_spikes     (in_spikes),
        .out_spikes    (out_spikes),
        .res_valid     (res_valid),
        .res_counts    (res_counts),
        .err_underflow (err_underflow),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int rv_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    // stage: 0 idle, 1 launching, 2 running, 3 draining, 4 done
    logic [N_IN:0]   mq[$];
    int              m_stage = 0;
    logic [N_IN-1:0] m_spk   = '0;
    bit              m_err   = 0;
    bit              m_alive = 0;
    bit              m_prev  = 0;
    int              m_cnt [N_OUT] = '{0, 0};

    function automatic bit frame_queued();
        foreach (mq[k]) if (mq[k][N_IN]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_stage = 0; m_spk = '0; m_err = 0; m_alive = 0; m_prev = 0;
        for (int i = 0; i < N_OUT; i++) m_cnt[i] = 0;
    endtask

    task automatic model_step();
        bit            rise;
        bit            acc;
        logic [N_IN:0] ent;
        rise = sample && !m_prev;
        acc  = wr_valid && m_alive && (mq.size() < DEPTH);
        m_prev  = sample;
        m_alive = 1;
        if (m_stage >= 1 && m_stage <= 3)
            for (int i = 0; i < N_OUT; i++)
                m_cnt[i] = (m_cnt[i] + out_spikes[i] > MAXC) ? MAXC : m_cnt[i] + out_spikes[i];
        case (m_stage)
            0: if (ready && frame_queued()) begin
                   m_stage = 1;
                   for (int i = 0; i < N_OUT; i++) m_cnt[i] = 0;
               end
            1: if (!ready) m_stage = 2;
            2: if (rise) begin
                   if (mq.size() > 0) begin
                       ent   = mq.pop_front();
                       m_spk = ent[N_IN-1:0];
                       if (ent[N_IN]) m_stage = 3;
                   end else begin
                       m_spk = '0; m_err = 1;
                   end
               end
            3: begin
                   if (rise && mq.size() == 0) begin m_spk = '0; m_err = 1; end
                   if (ready) m_stage = 4;
               end
            default: begin m_spk = '0; m_stage = 0; end
        endcase
        if (acc) mq.push_back({wr_last, wr_data});
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            check("wr_ready",      wr_ready,      m_alive && (mq.size() < DEPTH));
            check("start",         start,         m_stage == 1);
            check("busy",          busy,          m_stage >= 1 && m_stage <= 3);
            check("res_valid",     res_valid,     m_stage == 4);
            check("sample_ready",  sample_ready,  (m_stage == 1 || m_stage == 2) && mq.size() > 0);
            check("in_spikes",     in_spikes,     m_spk);
            check("err_underflow", err_underflow, m_err);
            check("res_counts",    res_counts,    (m_cnt[1] << CNT_W) | m_cnt[0]);
            if (res_valid) rv_seen++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [N_IN-1:0] d, input logic l);
        int n;
        n = 0;
        wr_valid = 1'b1; wr_data = d; wr_last = l;
        while (!wr_ready && n < 200) begin tick(); n++; end
        if (!wr_ready) check("write_timeout", wr_ready, 1);
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic launch();
        int n;
        n = 0;
        ready = 1'b1;
        while (!start && n < 50) begin tick(); n++; end
        check("start_seen", start, 1);
        ready = 1'b0;
        tick();
    endtask

    task automatic pulse(input int hold, output logic [N_IN-1:0] cap);
        sample = 1'b1;
        tick();
        cap = in_spikes;
        repeat (hold - 1) tick();
        sample = 1'b0;
        tick();
    endtask

    task automatic finish_frame();
        ready = 1'b1;
        tick();
        tick();
        check("busy_after_frame", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    logic [N_IN-1:0] cap;
    int              rv0;

    initial begin
        rst_n = 1'b0; wr_valid = 1'b0; wr_data = '0; wr_last = 1'b0;
        ready = 1'b0; sample = 1'b0; out_spikes = '0;
        repeat (3) tick();
        check("rst_wr_ready", wr_ready, 0);
        check("rst_in_spikes", in_spikes, 0);
        check("rst_res_counts", res_counts, 0);
        rst_n = 1'b1;
        tick();
        check("wr_ready_after_release", wr_ready, 1);

        // basic frame + counting
        ready = 1'b1;
        host_write(4'hF, 0); host_write(4'hE, 0); host_write(4'hD, 0); host_write(4'hC, 1);
        rv0 = rv_seen;
        launch();
        out_spikes = 2'b01; repeat (5) tick();
        out_spikes = 2'b11; repeat (3) tick();
        out_spikes = 2'b00;
        pulse(1, cap); check("basic_s0", cap, 4'hF);
        pulse(1, cap); check("basic_s1", cap, 4'hE);
        pulse(1, cap); check("basic_s2", cap, 4'hD);
        pulse(1, cap); check("basic_s3", cap, 4'hC);
        finish_frame();
        check("basic_res_valid_pulses", rv_seen - rv0, 1);
        check("count_totals", res_counts, 8'h38);

        // underflow after the last sample was consumed
        host_write(4'h5, 0); host_write(4'h6, 1);
        launch();
        pulse(1, cap); check("uf_s0", cap, 4'h5);
        pulse(1, cap); check("uf_s1", cap, 4'h6);
        pulse(1, cap); check("uf_spikes_zero", cap, 4'h0);
        check("uf_flag", err_underflow, 1);
        finish_frame();

        // backpressure and held sample
        ready = 1'b0;
        for (int i = 1; i <= 8; i++) host_write(N_IN'(i), i == 8);
        check("bp_full_after_8", wr_ready, 0);
        wr_valid = 1'b1; wr_data = 4'h9; wr_last = 1'b0;
        launch();
        check("bp_full_in_run", wr_ready, 0);
        sample = 1'b1;
        tick();
        check("bp_pop0", in_spikes, 4'h1);
        check("bp_ready_after_pop", wr_ready, 1);
        sample = 1'b0;
        tick();
        wr_valid = 1'b0;
        check("bp_full_after_9th", wr_ready, 0);
        pulse(4, cap); check("held_pop", cap, 4'h2);
        pulse(1, cap); check("held_next", cap, 4'h3);
        for (int i = 4; i <= 8; i++) begin
            pulse(1, cap);
            check("bp_seq", cap, 32'(i));
        end
        finish_frame();
        check("uf_sticky", err_underflow, 1);

        // reset in the middle of a run
        host_write(4'hA, 0); host_write(4'hB, 1);
        launch();
        out_spikes = 2'b11; repeat (2) tick(); out_spikes = 2'b00;
        pulse(1, cap); check("mid_s0", cap, 4'h9);
        rst_n = 1'b0;
        tick();
        check("mid_rst_busy", busy, 0);
        check("mid_rst_wr_ready", wr_ready, 0);
        rst_n = 1'b1;
        tick();
        check("mid_err_cleared", err_underflow, 0);
        check("mid_counts_cleared", res_counts, 0);
        ready = 1'b0;
        host_write(4'h7, 1);
        launch();
        out_spikes = 2'b01; repeat (2) tick(); out_spikes = 2'b00;
        pulse(1, cap); check("fresh_s0", cap, 4'h7);
        finish_frame();
        check("fresh_counts", res_counts, 8'h02);

        // saturation
        ready = 1'b0;
        host_write(4'h3, 1);
        launch();
        out_spikes = 2'b11; repeat (20) tick(); out_spikes = 2'b00;
        pulse(1, cap); check("sat_s0", cap, 4'h3);
        finish_frame();
        check("sat_counts", res_counts, 8'hFF);

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
